// File: rtl/mem_port_arbiter_if.sv
// Bundle of the fetch port, LSQ port and shared downstream memory port.
// The arbiter connects through the slave modport; the environment uses master.
interface mem_port_arbiter_if #(
  parameter int width = 32
);
  localparam int be_w = width / 8;

  logic              i_mem_read;
  logic              i_mem_write;
  logic [be_w-1:0]   i_mem_byte_enable;
  logic [width-1:0]  i_mem_address;
  logic [width-1:0]  i_mem_wdata;
  logic              i_mem_resp;
  logic [width-1:0]  i_mem_rdata;

  logic              lsq_mem_read;
  logic              lsq_mem_write;
  logic [be_w-1:0]   lsq_mem_byte_enable;
  logic [width-1:0]  lsq_mem_address;
  logic [width-1:0]  lsq_mem_wdata;
  logic              lsq_mem_resp;
  logic [width-1:0]  lsq_mem_rdata;

  logic              mem_read;
  logic              mem_write;
  logic [be_w-1:0]   mem_byte_enable;
  logic [width-1:0]  mem_address;
  logic [width-1:0]  mem_wdata;
  logic              mem_resp;
  logic [width-1:0]  mem_rdata;

  modport slave (
    input  i_mem_read, i_mem_write, i_mem_byte_enable, i_mem_address, i_mem_wdata,
    output i_mem_resp, i_mem_rdata,
    input  lsq_mem_read, lsq_mem_write, lsq_mem_byte_enable, lsq_mem_address, lsq_mem_wdata,
    output lsq_mem_resp, lsq_mem_rdata,
    output mem_read, mem_write, mem_byte_enable, mem_address, mem_wdata,
    input  mem_resp, mem_rdata
  );

  modport master (
    output i_mem_read, i_mem_write, i_mem_byte_enable, i_mem_address, i_mem_wdata,
    input  i_mem_resp, i_mem_rdata,
    output lsq_mem_read, lsq_mem_write, lsq_mem_byte_enable, lsq_mem_address, lsq_mem_wdata,
    input  lsq_mem_resp, lsq_mem_rdata,
    input  mem_read, mem_write, mem_byte_enable, mem_address, mem_wdata,
    output mem_resp, mem_rdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin 2:1 arbiter of fetch and LSQ ports onto one memory port.
// One transaction outstanding; downstream request is registered at grant.
module mem_port_arbiter #(
  parameter int width = 32
) (
  input  logic              clk,
  input  logic              rst,
  mem_port_arbiter_if.slave bus
);
  localparam int be_w = width / 8;

  typedef enum logic [1:0] {IDLE, I_BUSY, D_BUSY} state_e;
  typedef enum logic {GRANT_I, GRANT_L} grant_e;

  state_e            state_q, state_d;
  grant_e            last_grant_q, last_grant_d;
  logic              mem_read_q, mem_read_d;
  logic              mem_write_q, mem_write_d;
  logic [be_w-1:0]   mem_be_q, mem_be_d;
  logic [width-1:0]  mem_addr_q, mem_addr_d;
  logic [width-1:0]  mem_wdata_q, mem_wdata_d;

  logic i_req, lsq_req;
  logic grant_i, grant_l, go_idle;

  assign i_req   = bus.i_mem_read | bus.i_mem_write;
  assign lsq_req = bus.lsq_mem_read | bus.lsq_mem_write;

  // NOTE: every signal driven here gets a default first so no latch is inferred.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    mem_read_d   = mem_read_q;
    mem_write_d  = mem_write_q;
    mem_be_d     = mem_be_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    grant_i      = 1'b0;
    grant_l      = 1'b0;
    go_idle      = 1'b0;
    bus.i_mem_resp    = 1'b0;
    bus.i_mem_rdata   = '0;
    bus.lsq_mem_resp  = 1'b0;
    bus.lsq_mem_rdata = '0;

    unique case (state_q)
      IDLE: begin
        if (i_req && lsq_req) begin
          if (last_grant_q == GRANT_I) grant_l = 1'b1;
          else                         grant_i = 1'b1;
        end else if (i_req) begin
          grant_i = 1'b1;
        end else if (lsq_req) begin
          grant_l = 1'b1;
        end
      end
      I_BUSY: begin
        if (bus.mem_resp) begin
          bus.i_mem_resp  = 1'b1;
          bus.i_mem_rdata = bus.mem_rdata;
          if (lsq_req) grant_l = 1'b1;
          else         go_idle = 1'b1;
        end
      end
      D_BUSY: begin
        if (bus.mem_resp) begin
          bus.lsq_mem_resp  = 1'b1;
          bus.lsq_mem_rdata = bus.mem_rdata;
          if (i_req) grant_i = 1'b1;
          else       go_idle = 1'b1;
        end
      end
      default: go_idle = 1'b1;
    endcase

    // A simultaneous read+write request is forwarded as a write only.
    if (grant_i) begin
      state_d      = I_BUSY;
      last_grant_d = GRANT_I;
      mem_read_d   = bus.i_mem_read & ~bus.i_mem_write;
      mem_write_d  = bus.i_mem_write;
      mem_be_d     = bus.i_mem_byte_enable;
      mem_addr_d   = bus.i_mem_address;
      mem_wdata_d  = bus.i_mem_wdata;
    end else if (grant_l) begin
      state_d      = D_BUSY;
      last_grant_d = GRANT_L;
      mem_read_d   = bus.lsq_mem_read & ~bus.lsq_mem_write;
      mem_write_d  = bus.lsq_mem_write;
      mem_be_d     = bus.lsq_mem_byte_enable;
      mem_addr_d   = bus.lsq_mem_address;
      mem_wdata_d  = bus.lsq_mem_wdata;
    end else if (go_idle) begin
      state_d     = IDLE;
      mem_read_d  = 1'b0;
      mem_write_d = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      last_grant_q <= GRANT_I;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      mem_be_q     <= '0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      mem_read_q   <= mem_read_d;
      mem_write_q  <= mem_write_d;
      mem_be_q     <= mem_be_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
    end
  end

  assign bus.mem_read        = mem_read_q;
  assign bus.mem_write       = mem_write_q;
  assign bus.mem_byte_enable = mem_be_q;
  assign bus.mem_address     = mem_addr_q;
  assign bus.mem_wdata       = mem_wdata_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: directed stimulus pushes expected
// grants and responses; a negedge monitor pops and compares them.
module tb_mem_port_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  mem_port_arbiter_if #(.width(32)) bus ();

  mem_port_arbiter #(.width(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    logic        read;
    logic        write;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
  } req_t;

  typedef struct packed {
    logic        lsq;   // 0 = fetch owner, 1 = LSQ owner
    logic [31:0] data;
  } rsp_t;

  req_t grant_q[$];
  rsp_t resp_q[$];

  int checks = 0;
  int errors = 0;
  logic mon_en = 1'b0;
  logic prev_req = 1'b0;
  logic prev_resp = 1'b0;
  logic req_now;
  req_t exp_g;
  rsp_t exp_r;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic resp_cycle(input logic [31:0] d);
    bus.mem_resp  = 1'b1;
    bus.mem_rdata = d;
    tick();
    bus.mem_resp  = 1'b0;
    bus.mem_rdata = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  function automatic req_t mk_req(input logic r, input logic w, input logic [3:0] be,
                                  input logic [31:0] a, input logic [31:0] wd);
    mk_req = '{read: r, write: w, be: be, addr: a, wdata: wd};
  endfunction

  function automatic rsp_t mk_rsp(input logic l, input logic [31:0] d);
    mk_rsp = '{lsq: l, data: d};
  endfunction

  // Monitor: a new downstream request is one that appears from idle or
  // right after a completion; every resp pulse consumes one expected response.
  always @(negedge clk) begin
    if (mon_en) begin
      req_now = bus.mem_read | bus.mem_write;
      if (req_now && (!prev_req || prev_resp)) begin
        if (grant_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL grant: unexpected downstream request addr %0h at %0t", bus.mem_address, $time);
        end else begin
          exp_g = grant_q.pop_front();
          check("grant", {bus.mem_read, bus.mem_write, bus.mem_byte_enable,
                          bus.mem_address, bus.mem_wdata}, exp_g);
        end
      end
      if (bus.i_mem_resp || bus.lsq_mem_resp) begin
        if (resp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL resp: unexpected resp i=%0b lsq=%0b at %0t", bus.i_mem_resp, bus.lsq_mem_resp, $time);
        end else begin
          exp_r = resp_q.pop_front();
          check("resp_port", {bus.i_mem_resp, bus.lsq_mem_resp}, exp_r.lsq ? 2'b01 : 2'b10);
          check("resp_rdata", {bus.i_mem_rdata, bus.lsq_mem_rdata},
                exp_r.lsq ? {32'h0, exp_r.data} : {exp_r.data, 32'h0});
        end
      end else begin
        check("idle_rdata", {bus.i_mem_rdata, bus.lsq_mem_rdata}, 64'h0);
      end
      prev_req  = req_now;
      prev_resp = bus.mem_resp;
    end
  end

  initial begin
    bus.i_mem_read = 0; bus.i_mem_write = 0; bus.i_mem_byte_enable = 0;
    bus.i_mem_address = 0; bus.i_mem_wdata = 0;
    bus.lsq_mem_read = 0; bus.lsq_mem_write = 0; bus.lsq_mem_byte_enable = 0;
    bus.lsq_mem_address = 0; bus.lsq_mem_wdata = 0;
    bus.mem_resp = 0; bus.mem_rdata = 0;

    // Reset, then idle: all outputs stay zero; mem_resp in IDLE is ignored.
    tick();
    do_reset();
    mon_en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("reset_idle_outputs",
            {bus.mem_read, bus.mem_write, bus.mem_byte_enable, bus.mem_address, bus.mem_wdata,
             bus.i_mem_resp, bus.i_mem_rdata, bus.lsq_mem_resp, bus.lsq_mem_rdata}, '0);
      tick();
    end
    bus.mem_resp = 1'b1;
    bus.mem_rdata = 32'hFFFF_FFFF;
    @(negedge clk);
    check("idle_resp_ignored", {bus.i_mem_resp, bus.lsq_mem_resp}, 2'b00);
    tick();
    bus.mem_resp = 1'b0;
    bus.mem_rdata = '0;
    @(negedge clk);
    check("idle_after_stray_resp", {bus.mem_read, bus.mem_write}, 2'b00);
    tick();

    // Single fetch read: request cycle 1, grant cycle 2, resp cycle 5.
    grant_q.push_back(mk_req(1'b1, 1'b0, 4'hF, 32'h60, 32'h0));
    resp_q.push_back(mk_rsp(1'b0, 32'h13));
    bus.i_mem_read = 1; bus.i_mem_byte_enable = 4'hF; bus.i_mem_address = 32'h60;
    tick();
    @(negedge clk);
    check("fetch_grant_latency", {bus.mem_read, bus.mem_address}, {1'b1, 32'h60});
    tick();
    tick();
    tick();
    resp_cycle(32'h13);
    bus.i_mem_read = 0;
    @(negedge clk);
    check("fetch_done_read_low", bus.mem_read, 1'b0);
    tick();

    // Tie from reset: LSQ write wins first, fetch follows back-to-back.
    do_reset();
    grant_q.push_back(mk_req(1'b0, 1'b1, 4'hF, 32'h200, 32'hDEAD_BEEF));
    grant_q.push_back(mk_req(1'b1, 1'b0, 4'hF, 32'h100, 32'h0));
    resp_q.push_back(mk_rsp(1'b1, 32'h1234_5678));
    resp_q.push_back(mk_rsp(1'b0, 32'h1122_3344));
    bus.i_mem_read = 1; bus.i_mem_address = 32'h100;
    bus.lsq_mem_write = 1; bus.lsq_mem_address = 32'h200;
    bus.lsq_mem_wdata = 32'hDEAD_BEEF; bus.lsq_mem_byte_enable = 4'hF;
    tick();
    tick();
    resp_cycle(32'h1234_5678);
    bus.lsq_mem_write = 0;
    @(negedge clk);
    check("b2b_fetch_grant", {bus.mem_read, bus.mem_address}, {1'b1, 32'h100});
    tick();
    resp_cycle(32'h1122_3344);
    bus.i_mem_read = 0;
    tick();

    // Continuous requests from both ports: LSQ, I, LSQ, I, LSQ, I.
    for (int k = 0; k < 3; k++) begin
      grant_q.push_back(mk_req(1'b1, 1'b0, 4'hF, 32'h1000 + 4 * k, 32'h0));
      grant_q.push_back(mk_req(1'b1, 1'b0, 4'hF, 32'h2000 + 4 * k, 32'h0));
      resp_q.push_back(mk_rsp(1'b1, 32'hA0 + k));
      resp_q.push_back(mk_rsp(1'b0, 32'hB0 + k));
    end
    bus.lsq_mem_read = 1; bus.lsq_mem_address = 32'h1000; bus.lsq_mem_wdata = 0;
    bus.i_mem_read = 1; bus.i_mem_address = 32'h2000;
    for (int k = 0; k < 6; k++) begin
      tick();
      tick();
      if (k % 2 == 0) begin
        resp_cycle(32'hA0 + k / 2);
        if (k == 4) bus.lsq_mem_read = 0;
        else        bus.lsq_mem_address = 32'h1000 + 4 * (k / 2 + 1);
      end else begin
        resp_cycle(32'hB0 + k / 2);
        if (k == 5) bus.i_mem_read = 0;
        else        bus.i_mem_address = 32'h2000 + 4 * (k / 2 + 1);
      end
    end
    tick();

    // Non-owner changes ignored; read+write together becomes a write.
    grant_q.push_back(mk_req(1'b1, 1'b0, 4'h3, 32'h400, 32'h0));
    grant_q.push_back(mk_req(1'b0, 1'b1, 4'hC, 32'h300, 32'h55));
    resp_q.push_back(mk_rsp(1'b0, 32'hC0DE));
    resp_q.push_back(mk_rsp(1'b1, 32'h77));
    bus.i_mem_read = 1; bus.i_mem_byte_enable = 4'h3; bus.i_mem_address = 32'h400;
    tick();
    bus.lsq_mem_read = 1; bus.lsq_mem_address = 32'h280;
    tick();
    bus.lsq_mem_write = 1; bus.lsq_mem_address = 32'h300;
    bus.lsq_mem_wdata = 32'h55; bus.lsq_mem_byte_enable = 4'hC;
    @(negedge clk);
    check("owner_addr_held", {bus.mem_write, bus.mem_address}, {1'b0, 32'h400});
    tick();
    resp_cycle(32'hC0DE);
    bus.i_mem_read = 0;
    @(negedge clk);
    check("rw_becomes_write", {bus.mem_read, bus.mem_write}, 2'b01);
    tick();
    resp_cycle(32'h77);
    bus.lsq_mem_read = 0; bus.lsq_mem_write = 0;
    tick();

    // Reset during D_BUSY drops the transaction; late mem_resp is ignored.
    grant_q.push_back(mk_req(1'b1, 1'b0, 4'hF, 32'h500, 32'h0));
    bus.lsq_mem_read = 1; bus.lsq_mem_address = 32'h500;
    bus.lsq_mem_byte_enable = 4'hF; bus.lsq_mem_wdata = 0;
    tick();
    tick();
    rst = 1'b1;
    bus.lsq_mem_read = 0;
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("reset_mid_txn_outputs",
          {bus.mem_read, bus.mem_write, bus.mem_byte_enable, bus.mem_address, bus.mem_wdata}, '0);
    tick();
    bus.mem_resp = 1'b1;
    bus.mem_rdata = 32'h9999;
    @(negedge clk);
    check("late_resp_ignored", {bus.i_mem_resp, bus.lsq_mem_resp}, 2'b00);
    tick();
    bus.mem_resp = 1'b0;
    bus.mem_rdata = '0;
    @(negedge clk);
    check("idle_after_reset", {bus.mem_read, bus.mem_write}, 2'b00);
    tick();
    tick();

    check("grants_all_seen", grant_q.size(), 0);
    check("resps_all_seen", resp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
